// File: rtl/mccpu_pkg.sv
// mccpu_pkg: shared definitions for the multi-cycle MIPS-subset core.
//   - FSM state encoding and trap-cause codes
//   - opcode / funct constants of the supported instruction subset
//   - ALU operation codes, load/store size encoding
//   - a decoder that classifies an instruction for the FSM and datapath
package mccpu_pkg;

    typedef enum logic [2:0] {
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_ILLEGAL  = 2'd1,
        TRAP_MISALIGN = 2'd2,
        TRAP_TIMEOUT  = 2'd3
    } trap_e;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    // Coarse instruction class: all the FSM needs to pick its path.
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_JR,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } instr_cls_e;

    typedef struct packed {
        instr_cls_e cls;
        alu_op_e    alu_op;
        logic       use_imm;       // second ALU operand is the immediate
        logic       imm_zero_ext;  // logical immediates are zero-extended
        logic       dst_rt;        // destination is rt instead of rd
        mem_size_e  size;
        logic       load_unsigned;
        logic       is_bne;
        logic       is_jal;
    } decode_t;

    function automatic decode_t decode(input logic [5:0] op, input logic [5:0] funct);
        decode_t d;
        d.cls           = CLS_ILLEGAL;
        d.alu_op        = ALU_ADD;
        d.use_imm       = 1'b0;
        d.imm_zero_ext  = 1'b0;
        d.dst_rt        = 1'b0;
        d.size          = SZ_WORD;
        d.load_unsigned = 1'b0;
        d.is_bne        = 1'b0;
        d.is_jal        = 1'b0;
        case (op)
            OP_RTYPE: begin
                d.cls = CLS_ALU;
                case (funct)
                    FN_SLL:  d.alu_op = ALU_SLL;
                    FN_SRL:  d.alu_op = ALU_SRL;
                    FN_SRA:  d.alu_op = ALU_SRA;
                    FN_JR:   d.cls    = CLS_JR;
                    FN_ADDU: d.alu_op = ALU_ADD;
                    FN_SUBU: d.alu_op = ALU_SUB;
                    FN_AND:  d.alu_op = ALU_AND;
                    FN_OR:   d.alu_op = ALU_OR;
                    FN_XOR:  d.alu_op = ALU_XOR;
                    FN_NOR:  d.alu_op = ALU_NOR;
                    FN_SLT:  d.alu_op = ALU_SLT;
                    FN_SLTU: d.alu_op = ALU_SLTU;
                    default: d.cls    = CLS_ILLEGAL;
                endcase
            end
            OP_J:     d.cls = CLS_JUMP;
            OP_JAL: begin
                d.cls    = CLS_JUMP;
                d.is_jal = 1'b1;
            end
            OP_BEQ:   d.cls = CLS_BRANCH;
            OP_BNE: begin
                d.cls    = CLS_BRANCH;
                d.is_bne = 1'b1;
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                d.cls          = CLS_ALU;
                d.use_imm      = 1'b1;
                d.dst_rt       = 1'b1;
                d.imm_zero_ext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
                case (op)
                    OP_SLTI: d.alu_op = ALU_SLT;
                    OP_ANDI: d.alu_op = ALU_AND;
                    OP_ORI:  d.alu_op = ALU_OR;
                    OP_XORI: d.alu_op = ALU_XOR;
                    OP_LUI:  d.alu_op = ALU_LUI;
                    default: d.alu_op = ALU_ADD;
                endcase
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                d.cls           = CLS_LOAD;
                d.use_imm       = 1'b1;
                d.dst_rt        = 1'b1;
                d.load_unsigned = (op == OP_LBU) || (op == OP_LHU);
                d.size          = (op == OP_LW) ? SZ_WORD :
                                  ((op == OP_LH) || (op == OP_LHU)) ? SZ_HALF : SZ_BYTE;
            end
            OP_SB, OP_SH, OP_SW: begin
                d.cls     = CLS_STORE;
                d.use_imm = 1'b1;
                d.size    = (op == OP_SW) ? SZ_WORD : (op == OP_SH) ? SZ_HALF : SZ_BYTE;
            end
            default: d.cls = CLS_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mccpu_fsm.sv
// mccpu_fsm: control state machine of the multi-cycle core.
//   clk, rst        clock, synchronous active-high reset
//   mem_ready_i     memory handshake completion
//   cls_i           class of the instruction held in IR
//   misaligned_i    effective address of the current load/store is misaligned
//   state_o         current state (drives datapath enables)
//   mem_req_o       memory request (fetch in IF, data access in MEM)
//   mem_we_o        request is a store
//   mem_done_o      transfer completes on this edge
//   halt_o          core is stopped in TRAP
//   trap_cause_o    cause recorded on TRAP entry
module mccpu_fsm
    import mccpu_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ready_i,
    input  instr_cls_e cls_i,
    input  logic       misaligned_i,
    output state_e     state_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_done_o,
    output logic       halt_o,
    output logic [1:0] trap_cause_o
);

    state_e      state_q, state_d;
    trap_e       cause_q, cause_d;
    logic [31:0] stall_q, stall_d;
    logic        timeout;

    // Once the wait counter reaches the limit the request is withdrawn in
    // the same cycle, so a late mem_ready can never complete the transfer.
    assign timeout = (STALL_LIMIT != 0) && (stall_q == 32'(STALL_LIMIT));

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        case (state_q)
            ST_IF: begin
                if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) state_d = ST_ID;
                end
            end
            ST_ID: begin
                if (cls_i == CLS_ILLEGAL) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                case (cls_i)
                    CLS_ALU: state_d = ST_WB;
                    CLS_LOAD, CLS_STORE: begin
                        if (misaligned_i) begin
                            state_d = ST_TRAP;
                            cause_d = TRAP_MISALIGN;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    default: state_d = ST_IF;  // branches and jumps retire here
                endcase
            end
            ST_MEM: begin
                if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    mem_req_o = 1'b1;
                    mem_we_o  = (cls_i == CLS_STORE);
                    if (mem_ready_i) state_d = (cls_i == CLS_STORE) ? ST_IF : ST_WB;
                end
            end
            ST_WB:   state_d = ST_IF;
            default: state_d = ST_TRAP;  // TRAP is sticky until reset
        endcase
        // Reset abandons any in-flight request immediately.
        if (rst) begin
            mem_req_o = 1'b0;
            mem_we_o  = 1'b0;
        end
    end

    assign mem_done_o = mem_req_o && mem_ready_i;
    assign stall_d    = (mem_req_o && !mem_ready_i) ? stall_q + 32'd1 : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IF;
            cause_q <= TRAP_NONE;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            stall_q <= stall_d;
        end
    end

    assign state_o      = state_q;
    assign halt_o       = (state_q == ST_TRAP);
    assign trap_cause_o = cause_q;

endmodule

// File: rtl/mccpu.sv
// mccpu: multi-cycle MIPS-subset core with a single req/ready memory port.
//   clk, rst        clock, synchronous active-high reset
//   mem_req/mem_we  transfer request and direction (1 = write)
//   mem_addr        byte address; mem_be little-endian byte enables
//   mem_wdata       store data, byte/half replicated across lanes
//   mem_rdata       read data, valid with mem_ready
//   mem_ready       transfer completes this cycle
//   PC              address of the current instruction
//   halt            core stopped in TRAP; trap_cause gives the reason
//   reg_sel/reg_data combinational debug read of the register file
module mccpu
    import mccpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned STALL_LIMIT = 0,
    parameter int          NREG        = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] PC,
    output logic        halt,
    output logic [1:0]  trap_cause,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);

    localparam int RW = $clog2(NREG);

    state_e      state;
    logic        mem_done;
    logic        misaligned;
    decode_t     dec;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pcn_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] gpr_q [NREG];

    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext, op_b, alu_res, rs_val, rt_val, load_val;
    logic        taken;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;

    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};
    assign dec      = decode(ir_q[31:26], ir_q[5:0]);

    mccpu_fsm #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .mem_ready_i  (mem_ready),
        .cls_i        (dec.cls),
        .misaligned_i (misaligned),
        .state_o      (state),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_done_o   (mem_done),
        .halt_o       (halt),
        .trap_cause_o (trap_cause)
    );

    // Register file reads: indices beyond NREG read as zero; $0 is never written.
    assign rs_val   = (int'(rs) < NREG) ? gpr_q[rs[RW-1:0]] : 32'd0;
    assign rt_val   = (int'(rt) < NREG) ? gpr_q[rt[RW-1:0]] : 32'd0;
    assign reg_data = (int'(reg_sel) < NREG) ? gpr_q[reg_sel[RW-1:0]] : 32'd0;

    // ALU, used in EX for arithmetic results and load/store addresses.
    always_comb begin
        op_b = dec.use_imm ? (dec.imm_zero_ext ? imm_zext : imm_sext) : b_q;
        case (dec.alu_op)
            ALU_ADD:  alu_res = a_q + op_b;
            ALU_SUB:  alu_res = a_q - op_b;
            ALU_AND:  alu_res = a_q & op_b;
            ALU_OR:   alu_res = a_q | op_b;
            ALU_XOR:  alu_res = a_q ^ op_b;
            ALU_NOR:  alu_res = ~(a_q | op_b);
            ALU_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'd0, a_q < op_b};
            ALU_SLL:  alu_res = b_q << shamt;
            ALU_SRL:  alu_res = b_q >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(b_q) >>> shamt);
            ALU_LUI:  alu_res = {ir_q[15:0], 16'h0000};
            default:  alu_res = 32'd0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if (dec.cls == CLS_LOAD || dec.cls == CLS_STORE) begin
            case (dec.size)
                SZ_WORD: misaligned = (alu_res[1:0] != 2'b00);
                SZ_HALF: misaligned = alu_res[0];
                default: misaligned = 1'b0;
            endcase
        end
    end

    assign taken = (a_q == b_q) ^ dec.is_bne;

    always_comb begin
        pc_d = pc_q;
        case (state)
            ST_EX: begin
                case (dec.cls)
                    CLS_BRANCH: pc_d = taken ? pcn_q + {imm_sext[29:0], 2'b00} : pcn_q;
                    CLS_JUMP:   pc_d = {pcn_q[31:28], ir_q[25:0], 2'b00};
                    CLS_JR:     pc_d = a_q;
                    default:    pc_d = pc_q;
                endcase
            end
            ST_MEM:  if (mem_done && dec.cls == CLS_STORE) pc_d = pcn_q;
            ST_WB:   pc_d = pcn_q;
            default: pc_d = pc_q;
        endcase
    end

    // Select and extend the addressed lane of the read word.
    always_comb begin
        case (dec.size)
            SZ_BYTE: begin
                load_val = {24'd0, mem_rdata[{alu_q[1:0], 3'b000} +: 8]};
                if (!dec.load_unsigned) load_val[31:8] = {24{load_val[7]}};
            end
            SZ_HALF: begin
                load_val = {16'd0, mem_rdata[{alu_q[1], 4'b0000} +: 16]};
                if (!dec.load_unsigned) load_val[31:16] = {16{load_val[15]}};
            end
            default: load_val = mem_rdata;
        endcase
    end

    // Memory port: everything is driven from registers, so it is stable
    // for as long as a request waits for mem_ready.
    always_comb begin
        mem_addr  = (state == ST_IF) ? pc_q : alu_q;
        mem_be    = 4'hF;
        mem_wdata = b_q;
        if (state != ST_IF) begin
            case (dec.size)
                SZ_BYTE: begin
                    mem_be    = 4'b0001 << alu_q[1:0];
                    mem_wdata = {4{b_q[7:0]}};
                end
                SZ_HALF: begin
                    mem_be    = 4'b0011 << alu_q[1:0];
                    mem_wdata = {2{b_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'hF;
                    mem_wdata = b_q;
                end
            endcase
        end
    end

    // Register write port: jal links in EX, everything else writes in WB.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = dec.dst_rt ? rt : rd;
        wr_data = (dec.cls == CLS_LOAD) ? mdr_q : alu_q;
        if (state == ST_EX && dec.cls == CLS_JUMP && dec.is_jal) begin
            wr_en   = 1'b1;
            wr_idx  = 5'd31;
            wr_data = pcn_q;
        end else if (state == ST_WB) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: the GPR array is reset because software relies on zeroed
    // registers after reset; the internal IR/A/B/ALUOut/MDR latches below
    // are always written before being used and carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) gpr_q[i] <= 32'd0;
        end else if (wr_en && wr_idx != 5'd0 && int'(wr_idx) < NREG) begin
            gpr_q[wr_idx[RW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (state == ST_IF && mem_done) begin
            ir_q  <= mem_rdata;
            pcn_q <= pc_q + 32'd4;
        end
        if (state == ST_ID) begin
            a_q <= rs_val;
            b_q <= rt_val;
        end
        if (state == ST_EX) alu_q <= alu_res;
        if (state == ST_MEM && mem_done) mdr_q <= load_val;
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_mccpu.sv
// tb_mccpu: directed self-checking bench for mccpu (RESET_PC=0x3000,
// STALL_LIMIT=4) with a small byte-enabled memory model whose wait states
// are programmable.
module tb_mccpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, PC, reg_data;
    logic [3:0]  mem_be;
    logic [1:0]  trap_cause;
    logic [4:0]  reg_sel = 5'd0;

    logic [31:0] mem [4096];
    int          wait_n = 0;
    int          wcnt = 0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'd0, ld_data = 32'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mccpu #(
        .RESET_PC    (32'h0000_3000),
        .STALL_LIMIT (4),
        .NREG        (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .PC         (PC),
        .halt       (halt),
        .trap_cause (trap_cause),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data)
    );

    // Memory model: ready after wait_n stalled cycles of a request.
    assign mem_ready = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr[13:2]] <= ld_data;
        end else if (mem_req && mem_ready && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        reg_sel = r;
        #1;
        check(tag, reg_data, exp);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        tick(1);
        ld_en   = 1'b0;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---- Phase 1: zero-wait, reset state and basic latencies
        rst = 1'b1;
        wait_n = 0;
        tick(1);
        load(32'h3000, 32'h2401_0005);  // addiu $1,$0,5
        load(32'h3004, 32'h0021_1021);  // addu  $2,$1,$1
        load(32'h3008, 32'h8C04_1000);  // lw    $4,0x1000($0)
        load(32'h300C, 32'hA004_1005);  // sb    $4,0x1005($0)
        load(32'h1000, 32'hDEAD_BEEF);
        check("req_in_reset", {31'd0, mem_req}, 32'd0);
        release_rst();
        check("rst_mem_req", {31'd0, mem_req}, 32'd1);
        check("rst_mem_addr", mem_addr, 32'h3000);
        check("rst_pc", PC, 32'h3000);
        check("rst_halt_cause", {29'd0, halt, trap_cause}, 32'd0);
        check_reg("rst_r1", 5'd1, 32'd0);
        tick(7);
        check_reg("zw_r2_early", 5'd2, 32'd0);
        tick(1);
        check_reg("zw_r2", 5'd2, 32'd10);
        check_reg("zw_r1", 5'd1, 32'd5);
        check("zw_pc8", PC, 32'h3008);
        tick(4);
        check_reg("zw_lw_early", 5'd4, 32'd0);
        tick(1);
        check_reg("zw_lw", 5'd4, 32'hDEAD_BEEF);

        // ---- Phase 2: same program with 3 wait cycles per transfer
        rst = 1'b1;
        wait_n = 3;
        tick(1);
        load(32'h1004, 32'h0000_0000);
        release_rst();
        for (int k = 0; k < 4; k++) begin
            check("ws_fetch_addr", mem_addr, 32'h3000);
            check("ws_fetch_be_req", {27'd0, mem_req, mem_be}, {27'd0, 1'b1, 4'hF});
            tick(1);
        end
        tick(9);   // now after edge 13
        check_reg("ws_r2_early", 5'd2, 32'd0);
        tick(1);
        check_reg("ws_r2", 5'd2, 32'd10);
        tick(10);  // after edge 24
        check_reg("ws_lw_early", 5'd4, 32'd0);
        tick(1);
        check_reg("ws_lw", 5'd4, 32'hDEAD_BEEF);
        tick(6);   // after edge 31: sb in MEM, waiting
        for (int k = 0; k < 4; k++) begin
            check("ws_st_addr", mem_addr, 32'h1005);
            check("ws_st_be_we", {26'd0, mem_req, mem_we, mem_be}, {26'd0, 2'b11, 4'b0010});
            check("ws_st_wdata", mem_wdata, 32'hEFEF_EFEF);
            tick(1);
        end
        check("ws_st_mem", mem[12'h401], 32'h0000_EF00);
        check("ws_st_pc", PC, 32'h3010);

        // ---- Phase 3: byte store and byte/half loads, zero-wait
        rst = 1'b1;
        wait_n = 0;
        tick(1);
        load(32'h3000, 32'h2403_00AB);  // addiu $3,$0,0xAB
        load(32'h3004, 32'hA003_1002);  // sb    $3,0x1002($0)
        load(32'h3008, 32'h8005_1002);  // lb    $5,0x1002($0)
        load(32'h300C, 32'h9006_1002);  // lbu   $6,0x1002($0)
        load(32'h3010, 32'h8407_1002);  // lh    $7,0x1002($0)
        load(32'h1000, 32'h1122_3344);
        release_rst();
        tick(7);
        check("sb_addr", mem_addr, 32'h1002);
        check("sb_be_we", {26'd0, mem_req, mem_we, mem_be}, {26'd0, 2'b11, 4'b0100});
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        tick(1);
        check("sb_mem", mem[12'h400], 32'h11AB_3344);
        check("sb_pc", PC, 32'h3008);
        tick(5);
        check_reg("lb", 5'd5, 32'hFFFF_FFAB);
        tick(5);
        check_reg("lbu", 5'd6, 32'h0000_00AB);
        tick(5);
        check_reg("lh", 5'd7, 32'h0000_11AB);

        // ---- Phase 4: taken beq back onto itself
        rst = 1'b1;
        tick(1);
        load(32'h3000, 32'h0800_0040);  // j   0x100
        load(32'h0100, 32'h1000_FFFF);  // beq $0,$0,-1
        release_rst();
        tick(3);
        check("j_pc", PC, 32'h0100);
        check("j_fetch", mem_addr, 32'h0100);
        tick(3);
        check("beq_pc", PC, 32'h0100);
        check("beq_fetch", {31'd0, mem_req}, 32'd1);
        check("beq_fetch_addr", mem_addr, 32'h0100);

        // ---- Phase 5: bne not taken, jal, jr
        rst = 1'b1;
        tick(1);
        load(32'h0100, 32'h1400_0005);  // bne $0,$0,+5
        load(32'h0104, 32'h0800_0080);  // j   0x200
        load(32'h0200, 32'h0C00_00C0);  // jal 0x300
        load(32'h0300, 32'h03E0_0008);  // jr  $31
        release_rst();
        tick(6);
        check("bne_pc", PC, 32'h0104);
        tick(3);
        check("j2_pc", PC, 32'h0200);
        tick(3);
        check("jal_pc", PC, 32'h0300);
        check_reg("jal_r31", 5'd31, 32'h0204);
        tick(3);
        check("jr_pc", PC, 32'h0204);

        // ---- Phase 6: misaligned lw traps with no data request
        rst = 1'b1;
        tick(1);
        load(32'h3000, 32'h8C04_1001);  // lw $4,0x1001($0)
        release_rst();
        tick(2);
        check("mis_ex_state", {30'd0, halt, mem_req}, 32'd0);
        tick(1);
        check("mis_halt_cause", {29'd0, halt, trap_cause}, {29'd0, 1'b1, 2'd2});
        check("mis_pc", PC, 32'h3000);
        begin
            int reqs = 0;
            for (int k = 0; k < 5; k++) begin
                if (mem_req) reqs++;
                tick(1);
            end
            check("mis_no_req", 32'(reqs), 32'd0);
        end

        // ---- Phase 7: undefined opcode
        rst = 1'b1;
        tick(1);
        load(32'h3000, 32'hFC00_0000);
        release_rst();
        tick(2);
        check("ill_halt_cause", {29'd0, halt, trap_cause}, {29'd0, 1'b1, 2'd1});
        check("ill_pc", PC, 32'h3000);

        // ---- Phase 8: bus timeout, then reset recovery
        rst = 1'b1;
        wait_n = 1000;
        tick(1);
        release_rst();
        tick(3);
        check("to_req_4th", {30'd0, halt, mem_req}, 32'd1);
        tick(1);
        check("to_req_dropped", {30'd0, halt, mem_req}, 32'd0);
        tick(1);
        check("to_halt_cause", {29'd0, halt, trap_cause}, {29'd0, 1'b1, 2'd3});
        check("to_pc", PC, 32'h3000);
        rst = 1'b1;
        wait_n = 0;
        tick(1);
        check("to_rst_state", {28'd0, mem_req, halt, trap_cause}, 32'd0);
        release_rst();
        check("to_refetch", {31'd0, mem_req}, 32'd1);
        check("to_refetch_addr", mem_addr, 32'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
